// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-16 frame path.
// Contents:
//   CRC_W, POLY, INIT  - CRC-16/CCITT-FALSE constants, also used by crc_module
//   crc_frm_state_t    - frame sequencer state encoding
//   crc16_update_byte  - one-byte CRC step, available to crc_module and models
package crc_pkg;

   localparam int          CRC_W = 16;
   localparam logic [15:0] POLY  = 16'h1021;
   localparam logic [15:0] INIT  = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DATA     = 3'd1,
      ST_WAIT_CRC = 3'd2,
      ST_APP_HI   = 3'd3,
      ST_APP_LO   = 3'd4
   } crc_frm_state_t;

   // MSB-first CRC step over one byte; a zero seed argument is not special.
   function automatic logic [15:0] crc16_update_byte(input logic [15:0] crc_in,
                                                     input logic [7:0]  data_in);
      logic [15:0] crc_v;
      crc_v = crc_in ^ {data_in, 8'h00};
      for (int i = 0; i < 8; i++) begin
         if (crc_v[15]) begin
            crc_v = {crc_v[14:0], 1'b0} ^ POLY;
         end else begin
            crc_v = {crc_v[14:0], 1'b0};
         end
      end
      return crc_v;
   endfunction

endpackage

// File: rtl/crc_frame_obuf.sv
// One-entry output register for the frame sequencer.
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   load, d, last     - write a byte into the register (only when slot_free)
//   m_ready           - downstream accept
//   m_valid/m_data/m_last - registered downstream byte
//   slot_free         - register is empty or is being emptied this cycle
module crc_frame_obuf
   import crc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] d,
   input  logic       last,
   input  logic       m_ready,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   output logic       slot_free
);

   logic       m_valid_r;
   logic [7:0] m_data_r;
   logic       m_last_r;

   assign m_valid   = m_valid_r;
   assign m_data    = m_data_r;
   assign m_last    = m_last_r;
   assign slot_free = !m_valid_r || m_ready;

   // Output register: load wins, a handshake empties, a stall holds everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_r <= 1'b0;
         m_data_r  <= 8'h00;
         m_last_r  <= 1'b0;
      end else if (load) begin
         m_valid_r <= 1'b1;
         m_data_r  <= d;
         m_last_r  <= last;
      end else if (m_ready) begin
         m_valid_r <= 1'b0;
      end else begin
         m_valid_r <= m_valid_r;
      end
   end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the byte-wide CRC-16 engine. Forwards accepted payload
// bytes downstream while feeding them to the engine, then appends the engine
// result MSB first as two trailing bytes.
// Ports:
//   clk, reset                  - system clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last - upstream byte stream
//   m_valid/m_ready/m_data/m_last - downstream byte stream, m_last on CRC low byte
//   crc_init/crc_vld/crc_din    - engine controls (combinational, same cycle as accept)
//   crc_val                     - engine running CRC
//   frame_done, frame_len, err_oversize - per-frame status, registered
module crc_frame_ctrl
   import crc_pkg::*;
#(
   parameter int CRC_LAT = 1,
   parameter int LEN_W   = 12,
   parameter int MAX_LEN = 2048
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [7:0]       m_data,
   output logic             m_last,
   output logic             crc_init,
   output logic             crc_vld,
   output logic [7:0]       crc_din,
   input  logic [15:0]      crc_val,
   output logic             frame_done,
   output logic [LEN_W-1:0] frame_len,
   output logic             err_oversize
);

   crc_frm_state_t   state_r;
   logic [LEN_W-1:0] cnt_r;
   logic [2:0]       wait_cnt_r;
   logic [15:0]      crc_hold_r;
   logic             frame_done_r;
   logic [LEN_W-1:0] frame_len_r;
   logic             err_oversize_r;

   logic             slot_free_s;
   logic             s_ready_s;
   logic             accept_s;
   logic             load_s;
   logic [7:0]       obuf_d_s;
   logic             obuf_last_s;

   // Reset gating keeps the engine idle while the sequencer is being cleared.
   assign s_ready_s = !reset && slot_free_s &&
                      ((state_r == ST_IDLE) || (state_r == ST_DATA));
   assign accept_s  = s_valid && s_ready_s;

   assign s_ready      = s_ready_s;
   assign crc_vld      = accept_s;
   assign crc_init     = accept_s && (state_r == ST_IDLE);
   assign crc_din      = accept_s ? s_data : 8'h00;
   assign frame_done   = frame_done_r;
   assign frame_len    = frame_len_r;
   assign err_oversize = err_oversize_r;

   // Select what, if anything, enters the output register this cycle.
   always_comb begin
      load_s      = 1'b0;
      obuf_d_s    = 8'h00;
      obuf_last_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DATA: begin
            load_s   = accept_s;
            obuf_d_s = s_data;
         end
         ST_APP_HI: begin
            load_s   = slot_free_s;
            obuf_d_s = crc_hold_r[15:8];
         end
         ST_APP_LO: begin
            load_s      = slot_free_s;
            obuf_d_s    = crc_hold_r[7:0];
            obuf_last_s = 1'b1;
         end
         default: begin
            load_s = 1'b0;
         end
      endcase
   end

   crc_frame_obuf u_obuf (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s),
      .d         (obuf_d_s),
      .last      (obuf_last_s),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .slot_free (slot_free_s)
   );

   // Frame FSM with byte counter, CRC wait timer, CRC hold and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         cnt_r          <= '0;
         wait_cnt_r     <= 3'd0;
         crc_hold_r     <= 16'h0000;
         frame_done_r   <= 1'b0;
         frame_len_r    <= '0;
         err_oversize_r <= 1'b0;
      end else begin
         frame_done_r   <= 1'b0;
         err_oversize_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  cnt_r      <= LEN_W'(1);
                  wait_cnt_r <= 3'd0;
                  state_r    <= s_last ? ST_WAIT_CRC : ST_DATA;
               end
            end
            ST_DATA: begin
               if (accept_s) begin
                  // Counter sticks at all-ones rather than wrapping to a small length.
                  if (cnt_r != {LEN_W{1'b1}}) begin
                     cnt_r <= cnt_r + LEN_W'(1);
                  end
                  wait_cnt_r <= 3'd0;
                  if (s_last) begin
                     state_r <= ST_WAIT_CRC;
                  end
               end
            end
            ST_WAIT_CRC: begin
               // The final byte's CRC is settled on the CRC_LAT-th edge in this state.
               if (wait_cnt_r == 3'(CRC_LAT - 1)) begin
                  crc_hold_r <= crc_val;
                  state_r    <= ST_APP_HI;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 3'd1;
               end
            end
            ST_APP_HI: begin
               if (slot_free_s) begin
                  state_r <= ST_APP_LO;
               end
            end
            ST_APP_LO: begin
               if (slot_free_s) begin
                  frame_done_r   <= 1'b1;
                  frame_len_r    <= cnt_r;
                  err_oversize_r <= (32'(cnt_r) > 32'(MAX_LEN));
                  state_r        <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
module tb_crc_frame_ctrl;

   localparam int CRC_LAT = 2;
   localparam int LEN_W   = 6;
   localparam int MAX_LEN = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             s_valid, s_ready, s_last;
   logic [7:0]       s_data;
   logic             m_valid, m_ready, m_last;
   logic [7:0]       m_data;
   logic             crc_init, crc_vld;
   logic [7:0]       crc_din;
   logic [15:0]      crc_val;
   logic             frame_done, err_oversize;
   logic [LEN_W-1:0] frame_len;

   always #5 clk = ~clk;

   crc_frame_ctrl #(.CRC_LAT(CRC_LAT), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .crc_init(crc_init), .crc_vld(crc_vld), .crc_din(crc_din), .crc_val(crc_val),
      .frame_done(frame_done), .frame_len(frame_len), .err_oversize(err_oversize)
   );

   // Stand-in CRC engine: byte-wise update, result delayed to CRC_LAT cycles.
   function automatic logic [15:0] eng_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] v;
      v = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
      return v;
   endfunction

   logic [15:0] eng_r [CRC_LAT];
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < CRC_LAT; k++) eng_r[k] <= 16'hFFFF;
      end else begin
         if (crc_vld) eng_r[0] <= eng_step(crc_init ? 16'hFFFF : eng_r[0], crc_din);
         for (int k = 1; k < CRC_LAT; k++) eng_r[k] <= eng_r[k-1];
      end
   end
   assign crc_val = eng_r[CRC_LAT-1];

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct { logic [7:0] d; logic l; } exp_byte_t;
   typedef struct { logic [LEN_W-1:0] len; logic err; } exp_done_t;
   exp_byte_t exp_q[$];
   exp_done_t done_q[$];
   logic [7:0] tx_q[$];

   int         ready_pct = 100;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         frames_sent = 0;
   int         last_acc_cyc = 0;
   logic       last_done_err = 1'b0;
   logic       first_init_seen = 1'b0;
   logic [15:0] obs_crc = 16'h0000;
   logic [7:0]  prev_byte = 8'h00;
   logic        stall_prev = 1'b0;
   logic [9:0]  stall_val = 10'h000;

   // Reference CRC-16/CCITT-FALSE over the whole message as one bit stream.
   function automatic logic [15:0] crc_ref(input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++)
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ tx_q[i][b];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
         end
      return c;
   endfunction

   function automatic logic [LEN_W-1:0] sat_len(input int n);
      int mx;
      mx = (1 << LEN_W) - 1;
      return (n > mx) ? LEN_W'(mx) : LEN_W'(n);
   endfunction

   // Downstream driver: random backpressure at ready_pct percent.
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
   end

   // Monitor: scoreboard, stall stability, engine feed and status pulses.
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         chk("crc_vld_only_on_accept", 32'(crc_vld), 32'(s_valid && s_ready));
         chk("err_only_with_done", 32'(err_oversize && !frame_done), 32'd0);
         if (stall_prev) chk("stall_hold", 32'({m_valid, m_last, m_data}), 32'(stall_val));
         stall_prev = m_valid && !m_ready;
         stall_val  = {m_valid, m_last, m_data};
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               exp_byte_t e;
               e = exp_q.pop_front();
               chk("m_data", 32'(m_data), 32'(e.d));
               chk("m_last", 32'(m_last), 32'(e.l));
               if (m_last) obs_crc = {prev_byte, m_data};
               prev_byte = m_data;
            end
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            last_done_err = err_oversize;
            chk("done_with_crc_lo", 32'(m_valid && m_last), 32'd1);
            if (done_q.size() == 0) begin
               chk("unexpected_done", 32'(frame_len), 32'hFFFF_FFFF);
            end else begin
               exp_done_t d;
               d = done_q.pop_front();
               chk("frame_len", 32'(frame_len), 32'(d.len));
               chk("err_oversize", 32'(err_oversize), 32'(d.err));
            end
         end
      end
   end

   task automatic push_expect(input int n, input bit with_crc);
      logic [15:0] c;
      for (int i = 0; i < n; i++) exp_q.push_back('{d: tx_q[i], l: 1'b0});
      if (with_crc) begin
         c = crc_ref(n);
         exp_q.push_back('{d: c[15:8], l: 1'b0});
         exp_q.push_back('{d: c[7:0],  l: 1'b1});
         done_q.push_back('{len: sat_len(n), err: (n > MAX_LEN)});
         frames_sent++;
      end
   endtask

   // Offer the first n bytes of tx_q; checks engine controls on each accept.
   task automatic send_bytes(input int n, input bit mark_last, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         bit acc;
         int t;
         while (int'($urandom_range(0, 99)) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
         s_valid = 1'b1;
         s_data  = tx_q[i];
         s_last  = mark_last && (i == n - 1);
         acc = 1'b0;
         t = 0;
         while (!acc && t < 500) begin
            @(negedge clk);
            if (s_ready) begin
               acc = 1'b1;
               chk("crc_vld_on_accept", 32'(crc_vld), 32'd1);
               chk("crc_init_first_only", 32'(crc_init), 32'(i == 0));
               chk("crc_din", 32'(crc_din), 32'(s_data));
               if (i == 0) first_init_seen = crc_init && crc_vld;
            end
            @(posedge clk); #1;
            t++;
         end
         if (!acc) chk("send_timeout", 32'(i), 32'hFFFF_FFFF);
         last_acc_cyc = cyc;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (done_cnt < frames_sent && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("frame_done_seen", 32'(done_cnt), 32'(frames_sent));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_m_data"},  32'(m_data),  32'd0);
      chk({tag, "_m_last"},  32'(m_last),  32'd0);
      chk({tag, "_crc_ctl"}, 32'({crc_init, crc_vld, crc_din}), 32'd0);
      chk({tag, "_status"},  32'({frame_done, err_oversize, frame_len}), 32'd0);
   endtask

   typedef struct {
      int len; int rdy; int gap;
      logic [LEN_W-1:0] exp_len; logic exp_err;
   } vec_t;
   vec_t vecs[7];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{len: 1,  rdy: 100, gap: 0,  exp_len: 6'd1,  exp_err: 1'b0};
      vecs[1] = '{len: 4,  rdy: 100, gap: 0,  exp_len: 6'd4,  exp_err: 1'b0};
      vecs[2] = '{len: 5,  rdy: 100, gap: 0,  exp_len: 6'd5,  exp_err: 1'b1};
      vecs[3] = '{len: 64, rdy: 50,  gap: 0,  exp_len: 6'd63, exp_err: 1'b1};
      vecs[4] = '{len: 17, rdy: 70,  gap: 30, exp_len: 6'd17, exp_err: 1'b1};
      vecs[5] = '{len: 63, rdy: 100, gap: 20, exp_len: 6'd63, exp_err: 1'b1};
      vecs[6] = '{len: 3,  rdy: 30,  gap: 50, exp_len: 6'd3,  exp_err: 1'b0};

      reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk); #1;

      // 1: "123456789" with latency check
      ready_pct = 100;
      @(posedge clk); #1;
      tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      push_expect(9, 1'b1);
      send_bytes(9, 1'b1, 0);
      wait_done();
      chk("t1_crc", 32'(obs_crc), 32'h29B1);
      chk("t1_len", 32'(frame_len), 32'd9);
      chk("t1_latency", 32'(done_cyc - last_acc_cyc), 32'(CRC_LAT + 2));

      // 2: single byte frame
      tx_q = '{8'h55};
      push_expect(1, 1'b1);
      send_bytes(1, 1'b1, 0);
      wait_done();
      chk("t2_init_and_vld", 32'(first_init_seen), 32'd1);
      chk("t2_len", 32'(frame_len), 32'd1);

      // 4: back-to-back "AB" then "CD"
      tx_q = '{8'h41, 8'h42};
      push_expect(2, 1'b1);
      send_bytes(2, 1'b1, 0);
      tx_q = '{8'h43, 8'h44};
      first_init_seen = 1'b0;
      push_expect(2, 1'b1);
      send_bytes(2, 1'b1, 0);
      chk("t4_second_init", 32'(first_init_seen), 32'd1);
      wait_done();
      chk("t4_crc_cd", 32'(obs_crc), 32'(crc_ref(2)));

      // 5: reset after 3 bytes, then resend the whole frame
      tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
      push_expect(3, 1'b0);
      send_bytes(3, 1'b0, 0);
      repeat (4) @(posedge clk); #1;
      chk("t5_no_crc_before_reset", 32'(exp_q.size()), 32'd0);
      reset = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
      @(posedge clk);
      @(negedge clk);
      check_zero("t5_reset");
      @(posedge clk); #1;
      reset = 1'b0; s_valid = 1'b0;
      @(posedge clk); #1;
      chk("t5_done_count", 32'(done_cnt), 32'(frames_sent));
      push_expect(6, 1'b1);
      send_bytes(6, 1'b1, 0);
      wait_done();
      chk("t5_crc", 32'(obs_crc), 32'(crc_ref(6)));

      // Table-driven frames with random payload, stalls and gaps
      for (int v = 0; v < 7; v++) begin
         ready_pct = vecs[v].rdy;
         tx_q.delete();
         for (int i = 0; i < vecs[v].len; i++) tx_q.push_back(8'($urandom));
         push_expect(vecs[v].len, 1'b1);
         send_bytes(vecs[v].len, 1'b1, vecs[v].gap);
         wait_done();
         chk("tbl_len", 32'(frame_len), 32'(vecs[v].exp_len));
         chk("tbl_err", 32'(last_done_err), 32'(vecs[v].exp_err));
      end

      // Random frames
      for (int r = 0; r < 8; r++) begin
         int n;
         n = int'($urandom_range(1, 40));
         ready_pct = int'($urandom_range(30, 100));
         tx_q.delete();
         for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
         push_expect(n, 1'b1);
         send_bytes(n, 1'b1, int'($urandom_range(0, 40)));
      end
      wait_done();

      ready_pct = 100;
      repeat (10) @(posedge clk); #1;
      chk("end_exp_empty", 32'(exp_q.size()), 32'd0);
      chk("end_done_empty", 32'(done_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
